nonce_dispatcher: RTL and testbench

- Parametrised multi-core successor to the single-miner control path in the FPGA top level.
- Splits a 2^NONCE_W nonce space into 2^CHUNK_W-sized chunks and hands chunks to NUM_CORES hash cores, one dispatch per cycle.
- Latches the first winning nonce and the index of the core that found it, and broadcasts abort to all cores.
- Flags exhaustion when every chunk has been searched with no hit.
- Sits between the processor/UART control (start, nonce_base) and the hash cores, on the mining clock.

---
 rtl/nonce_dispatcher_if.sv | 36 +++
 rtl/nonce_dispatcher.sv | 165 ++++++++++++++++
 tb/tb_nonce_dispatcher.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/nonce_dispatcher_if.sv
// Control and hash-core bus of the nonce dispatcher.
// master = dispatcher side, slave = control/core side.
interface nonce_dispatcher_if #(
  parameter int NUM_CORES  = 4,
  parameter int NONCE_W    = 32,
  parameter int CHUNK_W    = 16,
  parameter int CORE_IDX_W = 4
);
  logic                           start;
  logic                           abort;
  logic [NONCE_W-1:0]             nonce_base;
  logic [NUM_CORES-1:0]           core_start;
  logic [NUM_CORES*NONCE_W-1:0]   core_chunk;
  logic                           core_abort;
  logic [NUM_CORES-1:0]           core_done;
  logic [NUM_CORES-1:0]           core_found;
  logic [NUM_CORES*NONCE_W-1:0]   core_nonce;
  logic                           busy;
  logic                           found;
  logic [NONCE_W-1:0]             found_nonce;
  logic [CORE_IDX_W-1:0]          found_core;
  logic                           exhausted;
  logic [NONCE_W-CHUNK_W:0]       chunks_issued;

  modport master (
    input  start, abort, nonce_base, core_done, core_found, core_nonce,
    output core_start, core_chunk, core_abort, busy, found, found_nonce,
           found_core, exhausted, chunks_issued
  );

  modport slave (
    output start, abort, nonce_base, core_done, core_found, core_nonce,
    input  core_start, core_chunk, core_abort, busy, found, found_nonce,
           found_core, exhausted, chunks_issued
  );
endinterface

// File: rtl/nonce_dispatcher.sv
// Nonce dispatcher: splits the nonce space into chunks, hands one chunk
// per cycle to an idle hash core, latches the first hit and flags
// exhaustion when the whole space was searched without a hit.

// Per-core slot: busy bit plus the chunk start nonce last handed out.
module nonce_dispatcher_slot #(
  parameter int NONCE_W = 32
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               clear,
  input  logic               done,
  input  logic               load,
  input  logic [NONCE_W-1:0] chunkIn,
  output logic               busy,
  output logic [NONCE_W-1:0] chunk
);
  // Load wins over done so a core can finish and be redispatched together.
  always_ff @(posedge clock) begin
    if (!reset) begin
      busy  <= 1'b0;
      chunk <= '0;
    end else begin
      if (clear)     busy <= 1'b0;
      else if (load) busy <= 1'b1;
      else if (done) busy <= 1'b0;
      if (load) chunk <= chunkIn;
    end
  end
endmodule

module nonce_dispatcher #(
  parameter int NUM_CORES  = 4,
  parameter int NONCE_W    = 32,
  parameter int CHUNK_W    = 16,
  parameter int CORE_IDX_W = 4
) (
  input  logic                clock,
  input  logic                reset,
  nonce_dispatcher_if.master  bus
);
  localparam int CNT_W = NONCE_W - CHUNK_W + 1;
  localparam logic [CNT_W-1:0]   TOTAL = {1'b1, {(CNT_W-1){1'b0}}};
  localparam logic [NONCE_W-1:0] STEP  = NONCE_W'(1) << CHUNK_W;

  typedef enum logic [1:0] {IDLE, RUN, FOUND, EXHAUSTED} stateT;

  stateT                  state, nextState;
  logic [NUM_CORES-1:0]   busyMask, hitMask, maskAfterDone, idleMask;
  logic [NUM_CORES-1:0]   idleOneHot, doneClr;
  logic                   hit, dispatch, exhaust, clearAll;
  logic [CORE_IDX_W-1:0]  hitIdx;
  logic [NONCE_W-1:0]     hitNonce;

  logic [NUM_CORES-1:0]   coreStart;
  logic                   coreAbort, busyQ, foundQ, exhaustedQ;
  logic [NONCE_W-1:0]     foundNonce, nextChunk;
  logic [CORE_IDX_W-1:0]  foundCore;
  logic [CNT_W-1:0]       chunksIssued;

  // State register.
  always_ff @(posedge clock) begin
    if (!reset) state <= IDLE;
    else        state <= nextState;
  end

  // Next state: abort beats a hit, a hit beats exhaustion.
  always_comb begin
    nextState = state;
    case (state)
      RUN: begin
        if (bus.abort)    nextState = IDLE;
        else if (hit)     nextState = FOUND;
        else if (exhaust) nextState = EXHAUSTED;
      end
      default: if (bus.start) nextState = RUN;
    endcase
  end

  // Decision logic: winning core, lowest idle core, dispatch/exhaust strobes.
  always_comb begin
    hitMask       = bus.core_found & busyMask;
    maskAfterDone = busyMask & ~bus.core_done;
    idleMask      = ~maskAfterDone;
    hitIdx        = '0;
    hitNonce      = '0;
    idleOneHot    = '0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (hitMask[i]) begin
        hitIdx   = CORE_IDX_W'(i);
        hitNonce = bus.core_nonce[i*NONCE_W +: NONCE_W];
      end
      if (idleMask[i]) begin
        idleOneHot    = '0;
        idleOneHot[i] = 1'b1;
      end
    end
    hit      = |hitMask;
    clearAll = (state == RUN) && (bus.abort || hit);
    dispatch = (state == RUN) && !bus.abort && !hit &&
               (chunksIssued < TOTAL) && (|idleMask);
    exhaust  = (state == RUN) && !bus.abort && !hit &&
               (chunksIssued == TOTAL) && (maskAfterDone == '0);
    doneClr  = ((state == RUN) && !bus.abort && !hit) ? bus.core_done : '0;
  end

  for (genvar g = 0; g < NUM_CORES; g++) begin : gSlot
    nonce_dispatcher_slot #(.NONCE_W(NONCE_W)) slot (
      .clock   (clock),
      .reset   (reset),
      .clear   (clearAll),
      .done    (doneClr[g]),
      .load    (dispatch && idleOneHot[g]),
      .chunkIn (nextChunk),
      .busy    (busyMask[g]),
      .chunk   (bus.core_chunk[g*NONCE_W +: NONCE_W])
    );
  end

  // Registered outputs, job bookkeeping and result latches.
  always_ff @(posedge clock) begin
    if (!reset) begin
      coreStart    <= '0;
      coreAbort    <= 1'b0;
      busyQ        <= 1'b0;
      foundQ       <= 1'b0;
      exhaustedQ   <= 1'b0;
      foundNonce   <= '0;
      foundCore    <= '0;
      chunksIssued <= '0;
      nextChunk    <= '0;
    end else begin
      coreStart <= dispatch ? idleOneHot : '0;
      coreAbort <= clearAll;
      busyQ     <= (nextState == RUN);
      if (state != RUN && bus.start) begin
        foundQ       <= 1'b0;
        exhaustedQ   <= 1'b0;
        foundNonce   <= '0;
        foundCore    <= '0;
        chunksIssued <= '0;
        nextChunk    <= bus.nonce_base & ~(STEP - NONCE_W'(1));
      end
      if (state == RUN && !bus.abort && hit) begin
        foundQ     <= 1'b1;
        foundNonce <= hitNonce;
        foundCore  <= hitIdx;
      end
      if (dispatch) begin
        nextChunk    <= nextChunk + STEP;
        chunksIssued <= chunksIssued + CNT_W'(1);
      end
      if (exhaust) exhaustedQ <= 1'b1;
    end
  end

  assign bus.core_start    = coreStart;
  assign bus.core_abort    = coreAbort;
  assign bus.busy          = busyQ;
  assign bus.found         = foundQ;
  assign bus.found_nonce   = foundNonce;
  assign bus.found_core    = foundCore;
  assign bus.exhausted     = exhaustedQ;
  assign bus.chunks_issued = chunksIssued;
endmodule

// File: tb/tb_nonce_dispatcher.sv
// Directed bench: a 4-core instance driven from a vector table and a
// 2-core instance driven by a hand-written redispatch sequence.
module tb_nonce_dispatcher;
  logic clock = 1'b0;
  logic rstA, rstB;
  always #5 clock = ~clock;

  nonce_dispatcher_if #(.NUM_CORES(4), .NONCE_W(10), .CHUNK_W(8), .CORE_IDX_W(4)) ifA ();
  nonce_dispatcher_if #(.NUM_CORES(2), .NONCE_W(10), .CHUNK_W(8), .CORE_IDX_W(4)) ifB ();

  nonce_dispatcher #(.NUM_CORES(4), .NONCE_W(10), .CHUNK_W(8), .CORE_IDX_W(4)) dutA (
    .clock(clock), .reset(rstA), .bus(ifA));
  nonce_dispatcher #(.NUM_CORES(2), .NONCE_W(10), .CHUNK_W(8), .CORE_IDX_W(4)) dutB (
    .clock(clock), .reset(rstB), .bus(ifB));

  typedef struct {
    logic st, ab; logic [9:0] base; logic [3:0] dn, fd; logic [39:0] nonce;
    logic [3:0] cs; logic cab, bsy, fnd; logic [9:0] fn; logic [3:0] fc;
    logic exh; logic [2:0] iss; logic [9:0] chunk;
  } vecT;

  vecT vecs[$];
  int passed = 0, total = 0;

  logic [24:0] outA;
  logic [22:0] outB;
  assign outA = {ifA.core_start, ifA.core_abort, ifA.busy, ifA.found, ifA.found_nonce,
                 ifA.found_core, ifA.exhausted, ifA.chunks_issued};
  assign outB = {ifB.core_start, ifB.core_abort, ifB.busy, ifB.found, ifB.found_nonce,
                 ifB.found_core, ifB.exhausted, ifB.chunks_issued};

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h required %h", name, got, exp);
  endtask

  task automatic row(input logic st, ab, input logic [9:0] base, input logic [3:0] dn, fd,
                     input logic [39:0] nonce, input logic [3:0] cs, input logic cab, bsy, fnd,
                     input logic [9:0] fn, input logic [3:0] fc, input logic exh,
                     input logic [2:0] iss, input logic [9:0] chunk);
    vecT v;
    v.st = st; v.ab = ab; v.base = base; v.dn = dn; v.fd = fd; v.nonce = nonce;
    v.cs = cs; v.cab = cab; v.bsy = bsy; v.fnd = fnd; v.fn = fn; v.fc = fc;
    v.exh = exh; v.iss = iss; v.chunk = chunk;
    vecs.push_back(v);
  endtask

  function automatic logic [22:0] expB(input logic [1:0] cs, input logic cab, bsy, fnd,
                                       input logic [9:0] fn, input logic [3:0] fc,
                                       input logic exh, input logic [2:0] iss);
    return {cs, cab, bsy, fnd, fn, fc, exh, iss};
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idleInputs();
    ifA.start = 0; ifA.abort = 0; ifA.nonce_base = 0; ifA.core_done = 0;
    ifA.core_found = 0; ifA.core_nonce = 0;
    ifB.start = 0; ifB.abort = 0; ifB.nonce_base = 0; ifB.core_done = 0;
    ifB.core_found = 0; ifB.core_nonce = 0;
  endtask

  initial begin
    // Table: inputs applied before an edge, outputs expected after it.
    //  st ab base    dn    fd    nonce                                    cs    cab bsy fnd fn      fc exh iss chunk
    row(1, 0, 10'h2A5, 4'h0, 4'h0, 40'h0,                                   4'h0, 0, 1, 0, 10'h000, 0, 0, 0, 10'h000);
    row(0, 0, 10'h000, 4'h0, 4'h0, 40'h0,                                   4'h1, 0, 1, 0, 10'h000, 0, 0, 1, 10'h200);
    row(0, 0, 10'h000, 4'h0, 4'h0, 40'h0,                                   4'h2, 0, 1, 0, 10'h000, 0, 0, 2, 10'h300);
    row(0, 0, 10'h000, 4'h0, 4'h0, 40'h0,                                   4'h4, 0, 1, 0, 10'h000, 0, 0, 3, 10'h000);
    row(0, 0, 10'h000, 4'h0, 4'h0, 40'h0,                                   4'h8, 0, 1, 0, 10'h000, 0, 0, 4, 10'h100);
    row(0, 0, 10'h000, 4'h0, 4'h0, 40'h0,                                   4'h0, 0, 1, 0, 10'h000, 0, 0, 4, 10'h000);
    row(0, 0, 10'h000, 4'hF, 4'h0, 40'h0,                                   4'h0, 0, 0, 0, 10'h000, 0, 1, 4, 10'h000);
    row(0, 0, 10'h000, 4'h0, 4'h0, 40'h0,                                   4'h0, 0, 0, 0, 10'h000, 0, 1, 4, 10'h000);
    row(1, 0, 10'h000, 4'h0, 4'h0, 40'h0,                                   4'h0, 0, 1, 0, 10'h000, 0, 0, 0, 10'h000);
    row(0, 0, 10'h000, 4'h0, 4'h0, 40'h0,                                   4'h1, 0, 1, 0, 10'h000, 0, 0, 1, 10'h000);
    row(1, 0, 10'h3FF, 4'h0, 4'h0, 40'h0,                                   4'h2, 0, 1, 0, 10'h000, 0, 0, 2, 10'h100);
    row(0, 0, 10'h000, 4'h1, 4'h0, 40'h0,                                   4'h1, 0, 1, 0, 10'h000, 0, 0, 3, 10'h200);
    row(0, 0, 10'h000, 4'h0, 4'h0, 40'h0,                                   4'h4, 0, 1, 0, 10'h000, 0, 0, 4, 10'h300);
    row(0, 0, 10'h000, 4'h0, 4'h6, {10'h000, 10'h012, 10'h3C7, 10'h000},    4'h0, 1, 0, 1, 10'h3C7, 1, 0, 4, 10'h000);
    row(0, 0, 10'h000, 4'h0, 4'h0, 40'h0,                                   4'h0, 0, 0, 1, 10'h3C7, 1, 0, 4, 10'h000);
    row(0, 0, 10'h000, 4'hF, 4'h8, {10'h111, 30'h0},                        4'h0, 0, 0, 1, 10'h3C7, 1, 0, 4, 10'h000);
    row(1, 0, 10'h100, 4'h0, 4'h0, 40'h0,                                   4'h0, 0, 1, 0, 10'h000, 0, 0, 0, 10'h000);
    row(0, 0, 10'h000, 4'h0, 4'h0, 40'h0,                                   4'h1, 0, 1, 0, 10'h000, 0, 0, 1, 10'h100);
    row(0, 1, 10'h000, 4'h0, 4'h1, {30'h0, 10'h155},                        4'h0, 1, 0, 0, 10'h000, 0, 0, 1, 10'h000);
    row(0, 0, 10'h000, 4'h0, 4'h1, {30'h0, 10'h155},                        4'h0, 0, 0, 0, 10'h000, 0, 0, 1, 10'h000);

    idleInputs();
    rstA = 0; rstB = 0;
    step(); step();
    check("resetA", {outA, ifA.core_chunk}, 65'h0);
    check("resetB", {outB, ifB.core_chunk}, 43'h0);
    rstA = 1; rstB = 1;

    foreach (vecs[i]) begin
      ifA.start = vecs[i].st; ifA.abort = vecs[i].ab; ifA.nonce_base = vecs[i].base;
      ifA.core_done = vecs[i].dn; ifA.core_found = vecs[i].fd; ifA.core_nonce = vecs[i].nonce;
      step();
      check($sformatf("row%0d", i), outA,
            {vecs[i].cs, vecs[i].cab, vecs[i].bsy, vecs[i].fnd, vecs[i].fn, vecs[i].fc,
             vecs[i].exh, vecs[i].iss});
      for (int k = 0; k < 4; k++)
        if (vecs[i].cs[k]) check($sformatf("row%0d_chunk", i), ifA.core_chunk[k*10 +: 10], vecs[i].chunk);
    end
    idleInputs();

    // Reset mid-RUN, then a fresh job restarts counting from zero.
    ifA.start = 1; ifA.nonce_base = 10'h000; step(); ifA.start = 0;
    step();
    check("midrun_dispatch", outA, {4'h1, 1'b0, 1'b1, 1'b0, 10'h0, 4'h0, 1'b0, 3'd1});
    rstA = 0; step(); rstA = 1;
    check("midrun_reset", {outA, ifA.core_chunk}, 65'h0);
    ifA.start = 1; ifA.nonce_base = 10'h300; step(); ifA.start = 0;
    check("restart_busy", outA, {4'h0, 1'b0, 1'b1, 1'b0, 10'h0, 4'h0, 1'b0, 3'd0});
    step();
    check("restart_first", outA, {4'h1, 1'b0, 1'b1, 1'b0, 10'h0, 4'h0, 1'b0, 3'd1});
    check("restart_chunk", ifA.core_chunk[9:0], 10'h300);

    // Two-core instance: stale hit from an idle core, redispatch after done.
    ifB.start = 1; ifB.nonce_base = 10'h000; step(); ifB.start = 0;
    check("b_start", outB, expB(2'b00, 0, 1, 0, 10'h0, 4'h0, 0, 3'd0));
    step();
    check("b_first", outB, expB(2'b01, 0, 1, 0, 10'h0, 4'h0, 0, 3'd1));
    check("b_chunk0", ifB.core_chunk[9:0], 10'h000);
    ifB.core_found = 2'b10; ifB.core_nonce = {10'h0AB, 10'h000}; step();
    ifB.core_found = 2'b00; ifB.core_nonce = '0;
    check("b_stale_found", outB, expB(2'b10, 0, 1, 0, 10'h0, 4'h0, 0, 3'd2));
    check("b_chunk1", ifB.core_chunk[19:10], 10'h100);
    ifB.core_done = 2'b01; step(); ifB.core_done = 2'b00;
    check("b_redispatch", outB, expB(2'b01, 0, 1, 0, 10'h0, 4'h0, 0, 3'd3));
    check("b_redisp_chunk", ifB.core_chunk[9:0], 10'h200);
    ifB.core_done = 2'b10; step(); ifB.core_done = 2'b00;
    check("b_last", outB, expB(2'b10, 0, 1, 0, 10'h0, 4'h0, 0, 3'd4));
    check("b_last_chunk", ifB.core_chunk[19:10], 10'h300);
    ifB.core_done = 2'b11; step(); ifB.core_done = 2'b00;
    check("b_exhausted", outB, expB(2'b00, 0, 0, 0, 10'h0, 4'h0, 1, 3'd4));
    step();
    check("b_hold", outB, expB(2'b00, 0, 0, 0, 10'h0, 4'h0, 1, 3'd4));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
